// File: rtl/around_pkg.sv
// Shared types and helpers for the multi-round AddRoundKey sequencer.
package around_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_ADDR_W = 16;
  localparam int ROT_MAX_W  = 1024;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    VRFY,
    DONE
  } state_e;

  // Byte rotate-left of the low w bits of v; bits above w come back as 0.
  function automatic logic [ROT_MAX_W-1:0] rotl_bytes(
    input logic [ROT_MAX_W-1:0] v,
    input int unsigned          w
  );
    logic [ROT_MAX_W-1:0] m;
    m = {ROT_MAX_W{1'b1}} >> (ROT_MAX_W - w);
    return ((v << 8) | (v >> (w - 8))) & m;
  endfunction

endpackage

// File: rtl/around_keysched.sv
// Round-key register: reloads the cipher key on start and
// rotates it left by one byte each time the round advances.
module around_keysched
  import around_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] key_i,
  input  logic              adv_i,
  output logic [DATA_W-1:0] rk_o
);

  logic [DATA_W-1:0] rk_q, rk_d;

  always_comb begin
    rk_d = rk_q;
    if (load_i) begin
      rk_d = key_i;
    end else if (adv_i) begin
      rk_d = DATA_W'(rotl_bytes(ROT_MAX_W'(rk_q), DATA_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_q <= '0;
    end else begin
      rk_q <= rk_d;
    end
  end

  assign rk_o = rk_q;

endmodule

// File: rtl/around_seq.sv
// NROUNDS AddRoundKey passes over an NWORDS SRAM block, in place.
// Optional write-verify re-read enabled by AROUND_VERIFY_EN.
module around_seq
  import around_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NWORDS   = 4,
  parameter int NROUNDS  = 10,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              around_enable,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] key,
  output logic              around_busy,
  output logic              around_finished,
  input  logic [DATA_W-1:0] sramReadValue,
  output logic [DATA_W-1:0] sramWriteValue,
  output logic              sramRead,
  output logic              sramWrite,
  output logic [ADDR_W-1:0] sramAddr,
  output logic              verify_err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int RW = $clog2(NROUNDS + 1);
  localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  state_e            state_q, state_d;
  logic [IW-1:0]     i_q, i_d;
  logic [RW-1:0]     r_q, r_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] cap_q, cap_d;

  logic              start, step, adv;
  logic              lat_end, last_w;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rk, wval;

  assign start   = (state_q == IDLE) && around_enable;
  assign lat_end = (lat_q == LW'(READ_LAT - 1));
  assign last_w  = (i_q == IW'(NWORDS - 1));
  assign addr    = base_q + ADDR_W'(i_q);
  assign wval    = cap_q ^ rk;

`ifdef AROUND_VERIFY_EN
  assign step = (state_q == VRFY) && lat_end;
`else
  assign step = (state_q == WRITE);
`endif
  assign adv = step && last_w;

  around_keysched #(
    .DATA_W(DATA_W)
  ) u_keysched (
    .clk   (clk),
    .rst   (rst),
    .load_i(start),
    .key_i (key),
    .adv_i (adv),
    .rk_o  (rk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q    <= '0;
      r_q    <= '0;
      lat_q  <= '0;
      base_q <= '0;
      cap_q  <= '0;
    end else begin
      i_q    <= i_d;
      r_q    <= r_d;
      lat_q  <= lat_d;
      base_q <= base_d;
      cap_q  <= cap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    r_d     = r_q;
    lat_d   = lat_q;
    base_d  = base_q;
    cap_d   = cap_q;
    unique case (state_q)
      IDLE: begin
        if (around_enable) begin
          state_d = READ;
          i_d     = '0;
          r_d     = '0;
          lat_d   = '0;
          base_d  = base_addr;
        end
      end
      READ: begin
        if (lat_end) begin
          cap_d   = sramReadValue;
          lat_d   = '0;
          state_d = WRITE;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      WRITE: begin
`ifdef AROUND_VERIFY_EN
        state_d = VRFY;
`endif
      end
      VRFY: begin
`ifdef AROUND_VERIFY_EN
        if (lat_end) begin
          lat_d = '0;
        end else begin
          lat_d = lat_q + LW'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (step) begin
      if (!last_w) begin
        i_d     = i_q + IW'(1);
        state_d = READ;
      end else begin
        i_d     = '0;
        r_d     = r_q + RW'(1);
        state_d = (r_q == RW'(NROUNDS - 1)) ? DONE : READ;
      end
    end
  end

  always_comb begin
    around_busy     = 1'b0;
    around_finished = 1'b0;
    sramRead        = 1'b0;
    sramWrite       = 1'b0;
    sramAddr        = '0;
    sramWriteValue  = '0;
    unique case (state_q)
      READ: begin
        around_busy = 1'b1;
        sramRead    = 1'b1;
        sramAddr    = addr;
      end
      WRITE: begin
        around_busy    = 1'b1;
        sramWrite      = 1'b1;
        sramAddr       = addr;
        sramWriteValue = wval;
      end
      VRFY: begin
        around_busy = 1'b1;
        sramRead    = 1'b1;
        sramAddr    = addr;
      end
      DONE:    around_finished = 1'b1;
      default: ;
    endcase
  end

`ifdef AROUND_VERIFY_EN
  logic              verr_q, verr_d;
  logic [ADDR_W-1:0] eaddr_q, eaddr_d;

  // Only the first failing address is kept until the next start.
  always_comb begin
    verr_d  = verr_q;
    eaddr_d = eaddr_q;
    if (start) begin
      verr_d  = 1'b0;
      eaddr_d = '0;
    end else if ((state_q == VRFY) && lat_end &&
                 (sramReadValue != wval) && !verr_q) begin
      verr_d  = 1'b1;
      eaddr_d = addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      verr_q  <= 1'b0;
      eaddr_q <= '0;
    end else begin
      verr_q  <= verr_d;
      eaddr_q <= eaddr_d;
    end
  end

  assign verify_err = verr_q;
  assign err_addr   = eaddr_q;
`else
  assign verify_err = 1'b0;
  assign err_addr   = '0;
`endif

endmodule

// File: tb/tb_around_seq.sv
// Directed bench for around_seq: a READ_LAT=1 and a READ_LAT=3
// instance, each with NWORDS=2, NROUNDS=2 and its own SRAM model.
module tb_around_seq;

`ifdef AROUND_VERIFY_EN
  localparam int VF = 1;
`else
  localparam int VF = 0;
`endif
  localparam int LAT1 = 2 * 2 * (1 + 1 + VF * 1) + 1;
  localparam int LAT3 = 2 * 2 * (3 + 1 + VF * 3) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         en1 = 0, en3 = 0;
  logic [15:0]  base1 = 0, base3 = 0;
  logic [127:0] key1 = 0, key3 = 0;
  logic         busy1, fin1, rd1, wr1, verr1;
  logic         busy3, fin3, rd3, wr3, verr3;
  logic [15:0]  addr1, eaddr1, addr3, eaddr3;
  logic [127:0] wval1, rdat1, wval3, rdat3;

  logic [127:0] mem1 [0:65535];
  logic [127:0] mem3 [0:65535];
  logic         pl_we = 0, pl_sel = 0, corrupt = 0;
  logic [15:0]  pl_addr = 0;
  logic [127:0] pl_data = 0;

  assign rdat1 = mem1[addr1];
  assign rdat3 = mem3[addr3];

  always @(posedge clk) begin
    if (pl_we && !pl_sel) mem1[pl_addr] <= pl_data;
    else if (wr1)
      mem1[addr1] <= (corrupt && addr1 == 16'h0011) ?
                     (wval1 ^ 128'h1) : wval1;
    if (pl_we && pl_sel) mem3[pl_addr] <= pl_data;
    else if (wr3) mem3[addr3] <= wval3;
  end

  around_seq #(.NWORDS(2), .NROUNDS(2), .READ_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .around_enable(en1),
    .base_addr(base1), .key(key1),
    .around_busy(busy1), .around_finished(fin1),
    .sramReadValue(rdat1), .sramWriteValue(wval1),
    .sramRead(rd1), .sramWrite(wr1), .sramAddr(addr1),
    .verify_err(verr1), .err_addr(eaddr1));

  around_seq #(.NWORDS(2), .NROUNDS(2), .READ_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .around_enable(en3),
    .base_addr(base3), .key(key3),
    .around_busy(busy3), .around_finished(fin3),
    .sramReadValue(rdat3), .sramWriteValue(wval3),
    .sramRead(rd3), .sramWrite(wr3), .sramAddr(addr3),
    .verify_err(verr3), .err_addr(eaddr3));

  int nchk = 0, nerr = 0;
  int bad_prot = 0, bad_addr = 0, bad_burst = 0, run3 = 0;
  logic [15:0] cur_base = 0;

  // Protocol monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (rd1 && wr1) bad_prot++;
    if (rd3 && wr3) bad_prot++;
    if (!rd1 && !wr1 && (addr1 != 0 || wval1 != 0)) bad_prot++;
    if (!rd3 && !wr3 && (addr3 != 0 || wval3 != 0)) bad_prot++;
    if (!wr1 && wval1 != 0) bad_prot++;
    if ((rd1 || wr1) && addr1 != cur_base &&
        addr1 != cur_base + 16'd1) bad_addr++;
    if (rd3) run3++;
    else if (run3 != 0) begin
      if (VF == 0 && run3 != 3) bad_burst++;
      if (VF == 1 && run3 % 3 != 0) bad_burst++;
      run3 = 0;
    end
  end

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input bit sel, input logic [15:0] a,
                         input logic [127:0] d);
    @(negedge clk);
    pl_we = 1; pl_sel = sel; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 0;
  endtask

  task automatic run_seq(input bit sel, input bit mid,
                         output int lat, output int nfin);
    lat = 0;
    nfin = 0;
    @(negedge clk);
    if (sel) en3 = 1; else en1 = 1;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin en1 = 0; en3 = 0; end
      if (mid && c == 3) en1 = 1;
      if (mid && c == 4) en1 = 0;
      if (sel ? fin3 : fin1) begin
        nfin++;
        if (lat == 0) lat = c;
      end
      if (lat != 0 && c >= lat + 3) break;
    end
  endtask

  typedef struct {
    logic [15:0]  base;
    logic [127:0] key;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] mask;
  } vec_t;

  vec_t vt [3];
  int lat, nfin;
  logic [15:0] a0, a1;

  initial begin
    vt[0] = '{16'h0010, 128'h01,
              128'hA5A5_A5A5_0000_1111_2222_3333_4444_5555,
              128'h0F0F_F0F0_1234_5678_9ABC_DEF0_CAFE_BABE,
              128'h0101};
    vt[1] = '{16'hFFFF, {8'hFF, 120'h0},
              128'h1111_2222_3333_4444_5555_6666_7777_8888,
              128'hDEAD_BEEF_0000_0000_FFFF_FFFF_0123_4567,
              {8'hFF, 112'h0, 8'hFF}};
    vt[2] = '{16'h1234,
              128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
              128'h0,
              128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
              128'h2266_22EE_2266_22EF_1133_1177_1133_1176};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out1", {busy1, fin1, rd1, wr1, verr1, addr1,
                         eaddr1, wval1}, '0);
    check("reset_out3", {busy3, fin3, rd3, wr3, verr3, addr3,
                         eaddr3, wval3}, '0);
    rst = 0;

    foreach (vt[k]) begin
      a0 = vt[k].base;
      a1 = vt[k].base + 16'd1;
      cur_base = vt[k].base;
      base1 = vt[k].base;
      key1 = vt[k].key;
      bad_addr = 0;
      preload(0, a0, vt[k].a);
      preload(0, a1, vt[k].b);
      run_seq(0, 0, lat, nfin);
      check($sformatf("v%0d_lat", k), lat, LAT1);
      check($sformatf("v%0d_nfin", k), nfin, 1);
      check($sformatf("v%0d_w0", k), mem1[a0], vt[k].a ^ vt[k].mask);
      check($sformatf("v%0d_w1", k), mem1[a1], vt[k].b ^ vt[k].mask);
      check($sformatf("v%0d_addr", k), bad_addr, 0);
      check($sformatf("v%0d_idle", k), {busy1, verr1}, 2'b00);
    end

    // READ_LAT=3 instance
    base3 = 16'h0010;
    key3 = 128'h01;
    preload(1, 16'h0010, vt[0].a);
    preload(1, 16'h0011, vt[0].b);
    run_seq(1, 0, lat, nfin);
    check("rl3_lat", lat, LAT3);
    check("rl3_nfin", nfin, 1);
    check("rl3_w0", mem3[16'h0010], vt[0].a ^ 128'h0101);
    check("rl3_w1", mem3[16'h0011], vt[0].b ^ 128'h0101);
    check("rl3_burst", bad_burst, 0);

    // around_enable re-pulsed mid-run is ignored
    cur_base = 16'h0010;
    base1 = 16'h0010;
    key1 = 128'h01;
    preload(0, 16'h0010, vt[0].a);
    preload(0, 16'h0011, vt[0].b);
    run_seq(0, 1, lat, nfin);
    check("mid_lat", lat, LAT1);
    check("mid_nfin", nfin, 1);
    check("mid_w0", mem1[16'h0010], vt[0].a ^ 128'h0101);
    check("mid_w1", mem1[16'h0011], vt[0].b ^ 128'h0101);

    // write to 0x11 corrupted by the SRAM model
    corrupt = 1;
    preload(0, 16'h0010, vt[0].a);
    preload(0, 16'h0011, vt[0].b);
    run_seq(0, 0, lat, nfin);
    corrupt = 0;
    check("vrf_lat", lat, LAT1);
    check("vrf_nfin", nfin, 1);
    check("vrf_err", verr1, 1'(VF));
    check("vrf_eaddr", eaddr1, (VF == 1) ? 16'h0011 : 16'h0000);

    // reset asserted during a WRITE cycle
    preload(0, 16'h0010, vt[0].a);
    preload(0, 16'h0011, vt[0].b);
    @(negedge clk);
    en1 = 1;
    @(negedge clk);
    en1 = 0;
    for (int c = 0; c < 20 && !wr1; c++) @(negedge clk);
    check("rst_sawwr", wr1, 1'b1);
    rst = 1;
    @(negedge clk);
    check("rst_abort", {busy1, fin1, rd1, wr1, verr1, addr1,
                        eaddr1, wval1}, '0);
    rst = 0;
    preload(0, 16'h0010, vt[0].a);
    preload(0, 16'h0011, vt[0].b);
    run_seq(0, 0, lat, nfin);
    check("rst_lat", lat, LAT1);
    check("rst_w0", mem1[16'h0010], vt[0].a ^ 128'h0101);
    check("rst_w1", mem1[16'h0011], vt[0].b ^ 128'h0101);
    check("rst_verr", verr1, 1'b0);

    check("protocol", bad_prot, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
